fetch_stage: RTL and testbench

//  IF stage of the 5-stage (IF ID EXE MEM WB) 8-bit core: holds the PC, fetches from

---
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage holding the PC, fetching over a req/ack handshake into the IF/ID register,
// with a one-entry skid buffer for ID stalls and branch redirect/flush of in-flight fetches.
module fetch_stage #(
    parameter int PC_W = 8,
    parameter int INSTR_W = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [2:0]         if_id_aux
);
    typedef enum logic [1:0] {REQ, SKID, DROP} state_t;
    state_t state;
    logic [PC_W-1:0] pc, req_addr, skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    // request is withdrawn while reset is held so memory sees the handshake abandoned
    assign imem_req = !rst && state != SKID;
    assign imem_addr = state == DROP ? req_addr : pc;
    assign if_id_aux = if_id_instr[2:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REQ;
            pc <= RESET_PC;
            req_addr <= RESET_PC;
            skid_pc <= '0;
            skid_instr <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc <= '0;
        end else if (redirect) begin
            pc <= redirect_pc;
            if_id_valid <= 1'b0;
            skid_pc <= '0;
            skid_instr <= '0;
            // an unanswered request must still complete; its word is thrown away in DROP
            if (state != SKID && !imem_ack) begin
                state <= DROP;
                req_addr <= imem_addr;
            end else begin
                state <= REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem_ack) begin
                        pc <= pc + 1'b1;
                        if (stall && if_id_valid) begin
                            skid_instr <= imem_rdata;
                            skid_pc <= pc;
                            state <= SKID;
                        end else begin
                            if_id_instr <= imem_rdata;
                            if_id_pc <= pc;
                            if_id_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        if_id_instr <= skid_instr;
                        if_id_pc <= skid_pc;
                        if_id_valid <= 1'b1;
                        state <= REQ;
                    end
                end
                DROP: begin
                    if (imem_ack) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; expected IF/ID words are queued by the stimulus and
// popped by monitors whenever ID consumes a valid, unstalled, unflushed instruction.
module tb_fetch_stage;
    logic clk = 0, rst = 1, stall = 0, redirect = 0;
    logic [7:0] redirect_pc = 0;
    logic imem_req, imem_ack, if_id_valid;
    logic [7:0] imem_addr, imem_rdata, if_id_instr, if_id_pc;
    logic [2:0] if_id_aux;
    logic ack_en = 0;
    int lat = 0, wait_cnt = 0;
    logic b_rst = 1, b_en = 0;
    logic b_req, b_ack, b_valid;
    logic [7:0] b_addr, b_rdata, b_instr, b_pc;
    logic [2:0] b_aux;
    int checks = 0, errors = 0;
    logic [18:0] qa[$], qb[$];
    logic p_req = 0, p_ack = 0;
    logic [7:0] p_addr = 0;

    always #5 clk = ~clk;

    assign imem_ack = ack_en && imem_req && wait_cnt >= lat;
    assign imem_rdata = imem_addr ^ 8'hA5;
    always @(posedge clk) wait_cnt <= (!imem_req || imem_ack || !ack_en) ? 0 : wait_cnt + 1;
    assign b_ack = b_en && b_req;
    assign b_rdata = b_addr ^ 8'hA5;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_aux(if_id_aux)
    );

    fetch_stage #(.RESET_PC(8'hFE)) dut_b (
        .clk(clk), .rst(b_rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(8'h00),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(b_rdata),
        .if_id_valid(b_valid), .if_id_instr(b_instr), .if_id_pc(b_pc), .if_id_aux(b_aux)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] ent(input logic [7:0] p);
        logic [7:0] i;
        i = p ^ 8'hA5;
        return {p, i, i[2:0]};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && if_id_valid && !stall && !redirect) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a: unexpected word pc %0h got %0h expected none", if_id_pc, if_id_instr);
            end else chk("sb_a", {if_id_pc, if_id_instr, if_id_aux}, qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!b_rst && b_valid) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b: unexpected word pc %0h got %0h expected none", b_pc, b_instr);
            end else chk("sb_b", {b_pc, b_instr, b_aux}, qb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && p_req && !p_ack) chk("addr_stable", imem_addr, p_addr);
        p_req <= imem_req && !rst;
        p_ack <= imem_ack;
        p_addr <= imem_addr;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        #7;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_instr", if_id_instr, 0);
        chk("rst_pc", if_id_pc, 0);
        chk("rst_addr", imem_addr, 0);
        cyc;
        rst = 0;
        ack_en = 1;
        #1;
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 0);
        chk("rel_valid", if_id_valid, 0);
        for (int i = 0; i < 8; i++) qa.push_back(ent(i[7:0]));
        cyc;
        chk("c2_valid", if_id_valid, 1);
        chk("c2_pc", if_id_pc, 0);
        repeat (6) cyc;
        cyc;
        ack_en = 0;
        cyc;
        lat = 2;
        ack_en = 1;
        for (int i = 8; i < 11; i++) qa.push_back(ent(i[7:0]));
        for (int j = 0; j < 3; j++) begin
            chk("w0_ack", imem_ack, 0);
            chk("w0_addr", imem_addr, 8 + j);
            cyc;
            chk("w1_addr", imem_addr, 8 + j);
            chk("w1_valid", if_id_valid, 0);
            cyc;
            chk("w2_ack", imem_ack, 1);
            chk("w2_addr", imem_addr, 8 + j);
            cyc;
        end
        ack_en = 0;
        cyc;
        lat = 0;
        ack_en = 1;
        for (int i = 11; i < 14; i++) qa.push_back(ent(i[7:0]));
        cyc;
        stall = 1;
        cyc;
        chk("skid_req", imem_req, 0);
        chk("skid_hold", if_id_pc, 11);
        cyc;
        chk("skid_req2", imem_req, 0);
        chk("skid_hold2", if_id_pc, 11);
        chk("skid_valid", if_id_valid, 1);
        cyc;
        stall = 0;
        chk("skid_hold3", if_id_pc, 11);
        cyc;
        chk("unskid_pc", if_id_pc, 12);
        chk("unskid_addr", imem_addr, 13);
        cyc;
        ack_en = 0;
        cyc;
        lat = 2;
        ack_en = 1;
        qa.push_back(ent(8'h40));
        qa.push_back(ent(8'h41));
        cyc;
        redirect = 1;
        redirect_pc = 8'h40;
        cyc;
        redirect = 0;
        chk("drop_addr", imem_addr, 14);
        chk("drop_req", imem_req, 1);
        chk("drop_valid", if_id_valid, 0);
        chk("drop_ack", imem_ack, 1);
        cyc;
        chk("redir_addr", imem_addr, 8'h40);
        chk("redir_valid", if_id_valid, 0);
        chk("redir_ack", imem_ack, 0);
        cyc;
        cyc;
        cyc;
        lat = 0;
        chk("redir_first", if_id_pc, 8'h40);
        chk("redir_first_v", if_id_valid, 1);
        cyc;
        ack_en = 0;
        cyc;
        ack_en = 1;
        cyc;
        stall = 1;
        cyc;
        redirect = 1;
        redirect_pc = 8'h10;
        chk("full_req", imem_req, 0);
        cyc;
        redirect = 0;
        stall = 0;
        chk("flush_valid", if_id_valid, 0);
        chk("flush_addr", imem_addr, 8'h10);
        chk("flush_req", imem_req, 1);
        qa.push_back(ent(8'h10));
        cyc;
        ack_en = 0;
        cyc;
        chk("flush_end", if_id_valid, 0);
        cyc;
        b_rst = 0;
        b_en = 1;
        #1;
        chk("b_rel_req", b_req, 1);
        chk("b_rel_addr", b_addr, 8'hFE);
        qb.push_back(ent(8'hFE));
        qb.push_back(ent(8'hFF));
        qb.push_back(ent(8'h00));
        qb.push_back(ent(8'h01));
        repeat (3) cyc;
        cyc;
        b_en = 0;
        cyc;
        b_en = 1;
        qb.push_back(ent(8'h02));
        cyc;
        cyc;
        chk("b_pre_valid", b_valid, 1);
        chk("b_pre_pc", b_pc, 8'h03);
        #2;
        b_rst = 1;
        #1;
        chk("b_arst_valid", b_valid, 0);
        chk("b_arst_addr", b_addr, 8'hFE);
        chk("b_arst_pc", b_pc, 0);
        chk("b_arst_req", b_req, 0);
        cyc;
        b_rst = 0;
        qb.push_back(ent(8'hFE));
        cyc;
        b_en = 0;
        repeat (3) cyc;
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
